// File: rtl/l1_ahb_pkg.sv
// Shared AHB definitions for the L1 AHB matrix.
// Holds the HTRANS/HBURST/HRESP encodings, the address-phase control bundle
// and a small helper that classifies a transfer type as active.
// The address is carried beside ahb_ctrl_t rather than inside it because its
// width is a per-instance parameter.
package l1_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Address-phase control bundle (address travels alongside).
  typedef struct packed {
    logic [1:0] trans;
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
    logic       lock;
  } ahb_ctrl_t;

  // NONSEQ and SEQ carry a real transfer; IDLE and BUSY do not.
  function automatic logic trans_active(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/l1_ahb_addr_hold.sv
// Address-phase hold buffer for one L1 AHB input stage.
// Captures the master's address phase when it cannot be accepted at once and
// presents either the buffered or the live address phase to the output stages.
// Ports:
//   HCLK, HRESET          clock, asynchronous active-high reset
//   capture               load the live address phase into the buffer
//   release_buf           buffered transfer accepted, free the buffer
//   live_sel/addr/ctrl    address phase as driven by the master
//   buf_valid             buffer holds a transfer awaiting acceptance
//   sel_m/addr_m/ctrl_m   address phase presented to the output stages
module l1_ahb_addr_hold
  import l1_ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  capture,
  input  logic                  release_buf,
  input  logic                  live_sel,
  input  logic [ADDR_WIDTH-1:0] live_addr,
  input  ahb_ctrl_t             live_ctrl,
  output logic                  buf_valid,
  output logic                  sel_m,
  output logic [ADDR_WIDTH-1:0] addr_m,
  output ahb_ctrl_t             ctrl_m
);

  logic [ADDR_WIDTH-1:0] buf_addr;
  ahb_ctrl_t             buf_ctrl;  // buf_ctrl.lock is the lock captured with the transfer

  // capture requires an empty buffer and release a full one, so they never collide.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_ctrl  <= '0;
    end else if (capture) begin
      buf_valid <= 1'b1;
      buf_addr  <= live_addr;
      buf_ctrl  <= live_ctrl;
    end else if (release_buf) begin
      buf_valid <= 1'b0;
    end
  end

  always_comb begin
    sel_m  = live_sel;
    addr_m = live_addr;
    ctrl_m = live_ctrl;
    if (buf_valid) begin
      sel_m  = 1'b1;
      addr_m = buf_addr;
      ctrl_m = buf_ctrl;
    end else if (!live_sel) begin
      // An unselected port must never look like a transfer to the output stages.
      ctrl_m.trans = HTRANS_IDLE;
    end
  end

endmodule

// File: rtl/l1_ahb_input_stage.sv
// Per-master input stage of the L1 AHB matrix.
// Presents the master's address phase as a request, parks it in a hold buffer
// (stalling the master) when the target output stage has not granted this
// port, replays it on grant, and routes the slave ready/response back during
// the data phase owned by this port.
// Ports:
//   HCLK, HRESET                  clock, asynchronous active-high reset
//   HSELS..HMASTLOCKS, HREADYS    master-side address phase and bus HREADY
//   HREADYOUTS, HRESPS            ready/response returned to the master
//   req                           address phase pending for an output stage
//   HSELM..HMASTLOCKM             address phase presented to the output stages
//   gnt, HREADYM, HRESPM          grant and data-phase signals from the output side
module l1_ahb_input_stage
  import l1_ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LOCK_HOLD  = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  output logic                  HREADYOUTS,
  output logic [1:0]            HRESPS,
  output logic                  req,
  output logic                  HSELM,
  output logic [ADDR_WIDTH-1:0] HADDRM,
  output logic [1:0]            HTRANSM,
  output logic                  HWRITEM,
  output logic [2:0]            HSIZEM,
  output logic [2:0]            HBURSTM,
  output logic [3:0]            HPROTM,
  output logic                  HMASTLOCKM,
  input  logic                  gnt,
  input  logic                  HREADYM,
  input  logic [1:0]            HRESPM
);

  logic      live_trans;
  logic      lock_idle;
  logic      accept;
  logic      capture;
  logic      release_buf;
  logic      buf_valid;
  logic      data_phase;
  ahb_ctrl_t live_ctrl;
  ahb_ctrl_t ctrl_m;

  assign live_ctrl = '{trans: HTRANSS, write: HWRITES, size: HSIZES, burst: HBURSTS,
                       prot: HPROTS, lock: HMASTLOCKS};

  assign live_trans = HSELS & HREADYS & trans_active(HTRANSS);
  // Keep the output stage parked on this port between transfers of a locked sequence.
  assign lock_idle  = (LOCK_HOLD != 0) & HSELS & HMASTLOCKS & (HTRANSS == HTRANS_IDLE);

  assign req         = buf_valid | live_trans | lock_idle;
  assign accept      = req & gnt & HREADYM;
  assign capture     = live_trans & ~buf_valid & ~accept;
  assign release_buf = buf_valid & accept;

  l1_ahb_addr_hold #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_hold (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .capture     (capture),
    .release_buf (release_buf),
    .live_sel    (HSELS),
    .live_addr   (HADDRS),
    .live_ctrl   (live_ctrl),
    .buf_valid   (buf_valid),
    .sel_m       (HSELM),
    .addr_m      (HADDRM),
    .ctrl_m      (ctrl_m)
  );

  assign HTRANSM    = ctrl_m.trans;
  assign HWRITEM    = ctrl_m.write;
  assign HSIZEM     = ctrl_m.size;
  assign HBURSTM    = ctrl_m.burst;
  assign HPROTM     = ctrl_m.prot;
  assign HMASTLOCKM = ctrl_m.lock;

  // The data phase advances only when the selected slave completes the current one.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      data_phase <= 1'b0;
    end else if (HREADYM) begin
      data_phase <= accept;
    end
  end

  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = HRESP_OKAY;
    if (buf_valid) begin
      HREADYOUTS = 1'b0;
    end else if (data_phase) begin
      HREADYOUTS = HREADYM;
    end
    if (data_phase) begin
      HRESPS = HRESPM;
    end
  end

endmodule

// File: tb/tb_l1_ahb_input_stage.sv
`timescale 1ns/1ps
module tb_l1_ahb_input_stage;
  import l1_ahb_pkg::*;

  localparam int unsigned AW = 32;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          HSELS;
  logic [AW-1:0] HADDRS;
  logic [1:0]    HTRANSS;
  logic          HWRITES;
  logic [2:0]    HSIZES;
  logic [2:0]    HBURSTS;
  logic [3:0]    HPROTS;
  logic          HMASTLOCKS;
  logic          HREADYS;
  logic          gnt;
  logic          HREADYM;
  logic [1:0]    HRESPM;

  logic          HREADYOUTS, req, HSELM, HWRITEM, HMASTLOCKM;
  logic [1:0]    HRESPS, HTRANSM;
  logic [AW-1:0] HADDRM;
  logic [2:0]    HSIZEM, HBURSTM;
  logic [3:0]    HPROTM;

  logic          nl_HREADYOUTS, nl_req, nl_HSELM, nl_HWRITEM, nl_HMASTLOCKM;
  logic [1:0]    nl_HRESPS, nl_HTRANSM;
  logic [AW-1:0] nl_HADDRM;
  logic [2:0]    nl_HSIZEM, nl_HBURSTM;
  logic [3:0]    nl_HPROTM;

  // Single master on the bus: its HREADY is what this stage returns.
  assign HREADYS = HREADYOUTS;

  always #5 HCLK = ~HCLK;

  l1_ahb_input_stage #(.ADDR_WIDTH(AW), .LOCK_HOLD(1)) u_dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
    .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
    .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .req(req), .HSELM(HSELM), .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM),
    .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTLOCKM(HMASTLOCKM),
    .gnt(gnt), .HREADYM(HREADYM), .HRESPM(HRESPM)
  );

  l1_ahb_input_stage #(.ADDR_WIDTH(AW), .LOCK_HOLD(0)) u_dut_nolock (
    .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
    .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
    .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS), .HREADYOUTS(nl_HREADYOUTS),
    .HRESPS(nl_HRESPS), .req(nl_req), .HSELM(nl_HSELM), .HADDRM(nl_HADDRM),
    .HTRANSM(nl_HTRANSM), .HWRITEM(nl_HWRITEM), .HSIZEM(nl_HSIZEM), .HBURSTM(nl_HBURSTM),
    .HPROTM(nl_HPROTM), .HMASTLOCKM(nl_HMASTLOCKM), .gnt(gnt), .HREADYM(HREADYM),
    .HRESPM(HRESPM)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic smp();
    @(negedge HCLK);
  endtask

  task automatic drive_addr(input logic sel, input logic [1:0] trans, input logic [AW-1:0] a,
                            input logic wr);
    HSELS = sel; HTRANSS = trans; HADDRS = a; HWRITES = wr;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [AW-1:0] addr;
    ahb_ctrl_t     ctrl;
    int            cyc;
  } exp_t;

  exp_t addr_q[$];
  bit   sb_en = 1'b0;
  bit   dp_exp;
  int   cyc_now = 0;

  always @(posedge HCLK) cyc_now <= cyc_now + 1;

  // Every address phase the master gets onto the bus must reach an output stage, in order.
  always @(negedge HCLK) begin
    if (sb_en && HSELS && HREADYS && HTRANSS[1]) begin
      exp_t e;
      e.addr = HADDRS;
      e.ctrl = '{trans: HTRANSS, write: HWRITES, size: HSIZES, burst: HBURSTS,
                 prot: HPROTS, lock: HMASTLOCKS};
      e.cyc  = cyc_now;
      addr_q.push_back(e);
    end
  end

  always @(negedge HCLK) begin
    if (sb_en) begin
      bit held, pend, acc;
      #2;
      pend = (addr_q.size() > 0);
      held = pend && (addr_q[0].cyc < cyc_now);
      chk("sb_req", req, pend);
      chk("sb_hreadyout", HREADYOUTS, held ? 1'b0 : (dp_exp ? HREADYM : 1'b1));
      chk("sb_hresp", HRESPS, dp_exp ? HRESPM : HRESP_OKAY);
      acc = pend && gnt && HREADYM;
      if (pend) begin
        chk("sb_haddrm", HADDRM, addr_q[0].addr);
        chk("sb_ctrlm", {HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTLOCKM},
            addr_q[0].ctrl);
        chk("sb_hselm", HSELM, 1'b1);
      end
      if (acc) void'(addr_q.pop_front());
      if (HREADYM) dp_exp = acc;
    end
  end

  // ---------------- stimulus ----------------
  logic [1:0] burst_seq [5];
  int         acc_cnt;

  initial begin
    HRESET = 1'b1;
    drive_addr(1'b0, HTRANS_IDLE, '0, 1'b0);
    HSIZES = 3'd2; HBURSTS = HBURST_SINGLE; HPROTS = 4'h3; HMASTLOCKS = 1'b0;
    gnt = 1'b0; HREADYM = 1'b1; HRESPM = HRESP_OKAY;

    // Reset state
    smp();
    chk("rst_hreadyout", HREADYOUTS, 1'b1);
    chk("rst_hresp", HRESPS, HRESP_OKAY);
    chk("rst_req", req, 1'b0);
    chk("rst_htransm", HTRANSM, HTRANS_IDLE);
    step();
    HRESET = 1'b0;

    // Granted NONSEQ write: zero-latency pass-through, data phase next cycle
    drive_addr(1'b1, HTRANS_NONSEQ, 32'h2000_0010, 1'b1);
    gnt = 1'b1; HREADYM = 1'b1;
    smp();
    chk("t1_req", req, 1'b1);
    chk("t1_haddrm", HADDRM, 32'h2000_0010);
    chk("t1_hwritem", HWRITEM, 1'b1);
    chk("t1_hreadyout", HREADYOUTS, 1'b1);
    step();
    drive_addr(1'b0, HTRANS_IDLE, '0, 1'b0);
    HREADYM = 1'b0;
    smp();
    chk("t1_dp_wait", HREADYOUTS, 1'b0);
    chk("t1_dp_req", req, 1'b0);
    step();
    HREADYM = 1'b1;
    smp();
    chk("t1_dp_done", HREADYOUTS, 1'b1);
    step();
    HREADYM = 1'b0;
    smp();
    chk("t1_after_dp", HREADYOUTS, 1'b1);
    step();

    // Ungranted NONSEQ read: buffered, master stalled, replayed on grant
    drive_addr(1'b1, HTRANS_NONSEQ, 32'h0000_0100, 1'b0);
    gnt = 1'b0; HREADYM = 1'b1;
    smp();
    chk("t2_req0", req, 1'b1);
    chk("t2_rdy0", HREADYOUTS, 1'b1);
    step();
    HADDRS = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) gnt = 1'b1;
      smp();
      chk("t2_hold_rdy", HREADYOUTS, 1'b0);
      chk("t2_hold_addr", HADDRM, 32'h0000_0100);
      chk("t2_hold_trans", HTRANSM, HTRANS_NONSEQ);
      step();
    end
    drive_addr(1'b0, HTRANS_IDLE, '0, 1'b0);
    HRESPM = HRESP_ERROR;
    smp();
    chk("t2_dp_rdy", HREADYOUTS, 1'b1);
    chk("t2_dp_resp", HRESPS, HRESP_ERROR);
    chk("t2_dp_req", req, 1'b0);
    step();
    smp();
    chk("t2_post_resp", HRESPS, HRESP_OKAY);
    step();

    // Wait states then two-cycle ERROR
    drive_addr(1'b1, HTRANS_NONSEQ, 32'h0000_0300, 1'b1);
    gnt = 1'b1; HREADYM = 1'b1; HRESPM = HRESP_OKAY;
    smp();
    chk("t3_addr_rdy", HREADYOUTS, 1'b1);
    step();
    drive_addr(1'b0, HTRANS_IDLE, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      HREADYM = (i == 3);
      HRESPM  = (i >= 2) ? HRESP_ERROR : HRESP_OKAY;
      smp();
      chk("t3_rdy", HREADYOUTS, (i == 3) ? 1'b1 : 1'b0);
      chk("t3_resp", HRESPS, (i >= 2) ? HRESP_ERROR : HRESP_OKAY);
      step();
    end
    HRESPM = HRESP_OKAY; HREADYM = 1'b1;

    // INCR4 with one BUSY, always granted
    burst_seq[0] = HTRANS_NONSEQ; burst_seq[1] = HTRANS_SEQ; burst_seq[2] = HTRANS_BUSY;
    burst_seq[3] = HTRANS_SEQ;    burst_seq[4] = HTRANS_SEQ;
    HBURSTS = HBURST_INCR4;
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      logic [AW-1:0] a;
      a = 32'h0000_0400 + 32'(4 * ((i > 2) ? i - 1 : i));
      drive_addr(1'b1, burst_seq[i], a, 1'b1);
      smp();
      chk("t4_htransm", HTRANSM, burst_seq[i]);
      chk("t4_req", req, (burst_seq[i] != HTRANS_BUSY));
      chk("t4_haddrm", HADDRM, a);
      if (req && gnt && HREADYM) acc_cnt++;
      step();
    end
    chk("t4_accepts", 64'(acc_cnt), 64'd4);
    drive_addr(1'b0, HTRANS_IDLE, '0, 1'b0);
    HBURSTS = HBURST_SINGLE;
    step();

    // Locked IDLE keeps the request up only with LOCK_HOLD=1
    gnt = 1'b0;
    drive_addr(1'b1, HTRANS_IDLE, 32'h0000_0500, 1'b0);
    HMASTLOCKS = 1'b1;
    smp();
    chk("t5_req_lock", req, 1'b1);
    chk("t5_hmastlockm", HMASTLOCKM, 1'b1);
    chk("t5_req_nolock", nl_req, 1'b0);
    step();
    HMASTLOCKS = 1'b0;
    drive_addr(1'b0, HTRANS_IDLE, '0, 1'b0);
    step();

    // Reset during a hold clears everything without waiting for a clock
    drive_addr(1'b1, HTRANS_NONSEQ, 32'h0000_0600, 1'b0);
    gnt = 1'b0;
    step();
    smp();
    chk("t6_held_rdy", HREADYOUTS, 1'b0);
    chk("t6_held_req", req, 1'b1);
    #2;
    HRESET = 1'b1;
    drive_addr(1'b0, HTRANS_IDLE, '0, 1'b0);
    #1;
    chk("t6_rst_rdy", HREADYOUTS, 1'b1);
    chk("t6_rst_req", req, 1'b0);
    chk("t6_rst_trans", HTRANSM, HTRANS_IDLE);
    step();
    HRESET = 1'b0;
    step();

    // Randomised traffic against the scoreboard
    dp_exp = 1'b0;
    sb_en  = 1'b1;
    for (int c = 0; c < 3100; c++) begin
      logic rdy;
      @(negedge HCLK);
      #3;
      rdy = HREADYS;
      @(posedge HCLK);
      #1;
      gnt     = ($urandom_range(0, 9) < 7);
      HREADYM = ($urandom_range(0, 9) < 7);
      HRESPM  = ($urandom_range(0, 4) == 0) ? HRESP_ERROR : HRESP_OKAY;
      if (rdy) begin
        if (c >= 3000) begin
          drive_addr(1'b0, HTRANS_IDLE, '0, 1'b0);
        end else begin
          int t;
          t = $urandom_range(0, 99);
          HSELS   = ($urandom_range(0, 99) < 85);
          HTRANSS = (t < 20) ? HTRANS_IDLE : (t < 30) ? HTRANS_BUSY :
                    (t < 70) ? HTRANS_NONSEQ : HTRANS_SEQ;
          HADDRS  = $urandom;
          HWRITES = 1'($urandom);
          HSIZES  = 3'($urandom);
          HBURSTS = 3'($urandom);
          HPROTS  = 4'($urandom);
        end
      end
    end
    @(negedge HCLK);
    #4;
    sb_en = 1'b0;
    chk("sb_drained", 64'(addr_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
